// File: rtl/rom_word_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_pkg
//  Description : Shared constants and FSM state type for the ROM word
//                arbiter slice (word/byte widths, word address width).
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    localparam int ROM_WORD_AW = 19;               // word address width
    localparam int ROM_BYTE_W  = 8;                // ROM byte width
    localparam int ROM_WORD_W  = 16;               // assembled word width
    localparam int ROM_BYTE_AW = ROM_WORD_AW + 1;  // byte address width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rom_word_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_word_arb_if
//  Description : Bundle of the two requester ports, the shared read-data
//                return and the byte-wide asynchronous ROM port.
//                slave  : seen by the arbiter (rom_word_arb)
//                master : seen by requesters / ROM model
//  Ports       : req0/addr0, req1/addr1 (requests), gnt0/gnt1 (grant pulses),
//                rvalid0/rvalid1 (data-valid pulses), rdata (word),
//                busy, rom_address (byte address), rom_datain (ROM byte)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_word_arb_if;
    import rom_arb_pkg::*;

    logic                   req0;
    logic [ROM_WORD_AW-1:0] addr0;
    logic                   req1;
    logic [ROM_WORD_AW-1:0] addr1;
    logic                   gnt0;
    logic                   gnt1;
    logic                   rvalid0;
    logic                   rvalid1;
    logic [ROM_WORD_W-1:0]  rdata;
    logic                   busy;
    logic [ROM_BYTE_AW-1:0] rom_address;
    logic [ROM_BYTE_W-1:0]  rom_datain;

    modport slave (
        input  req0, addr0, req1, addr1, rom_datain,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, rom_address
    );

    modport master (
        output req0, addr0, req1, addr1, rom_datain,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, rom_address
    );

endinterface : rom_word_arb_if
`default_nettype wire

// File: rtl/rom_word_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way combinational arbiter. A lone requester always wins;
//                on a tie the port that was NOT granted last wins.
//  Ports       : i_req[1:0] request pair, i_last last-granted port id,
//                o_gnt[1:0] one-hot grant (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last,
    output logic      [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rom_word_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rom_word_arb
//  Description : Arbitrates two 16-bit word-fetch ports onto one byte-wide
//                asynchronous ROM. Each word takes two cycles (HI byte, then
//                LO byte); a pending request at the LO-exit edge is accepted
//                directly so continuous traffic sustains one word / 2 cycles.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous, active-low reset
//                bus   - rom_word_arb_if.slave (requests, grants, rvalids,
//                        rdata, busy, ROM address/data)
//  Config      : ROM_ARB_FIXED_PRIO_EN - when defined port 0 always wins ties
//                and no round-robin pointer is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_word_arb
    import rom_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    rom_word_arb_if.slave   bus
);

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             w_req;
    logic [1:0]             w_grant;
    logic                   w_accept;
    logic                   w_last;
    logic [ROM_WORD_AW-1:0] r_addr;
    logic                   r_id;
    logic                   r_gnt0;
    logic                   r_gnt1;
    logic                   r_rvalid0;
    logic                   r_rvalid1;
    logic [ROM_WORD_W-1:0]  r_rdata;
    logic                   w_busy;
    logic [ROM_BYTE_AW-1:0] w_rom_address;

    assign w_req    = {bus.req1, bus.req0};
    // Arbitration happens only on edges that leave IDLE or LO.
    assign w_accept = ((r_state == IDLE) || (r_state == LO)) && (|w_req);

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_last (w_last),
        .o_gnt  (w_grant)
    );

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Pretend port 1 was always granted last, so port 0 wins every tie.
    assign w_last = 1'b1;
`else
    logic r_last;

    // Reset value 1 makes port 0 the winner of the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= 1'b1;
        else if (w_accept)
            r_last <= w_grant[1];
    end

    assign w_last = r_last;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? HI : IDLE;
            HI:      w_next = LO;
            LO:      w_next = w_accept ? HI : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        w_busy        = 1'b0;
        w_rom_address = '0;
        case (r_state)
            HI: begin
                w_busy        = 1'b1;
                w_rom_address = {r_addr, 1'b0};
            end
            LO: begin
                w_busy        = 1'b1;
                w_rom_address = {r_addr, 1'b1};
            end
            default: begin
                w_busy        = 1'b0;
                w_rom_address = '0;
            end
        endcase
    end

    // Request latch, grant/valid pulses and word assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_id      <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (w_accept) begin
                r_addr <= w_grant[1] ? bus.addr1 : bus.addr0;
                r_id   <= w_grant[1];
                r_gnt0 <= w_grant[0];
                r_gnt1 <= w_grant[1];
            end
            if (r_state == HI)
                r_rdata[15:8] <= bus.rom_datain;
            if (r_state == LO) begin
                r_rdata[7:0] <= bus.rom_datain;
                r_rvalid0    <= ~r_id;
                r_rvalid1    <= r_id;
            end
        end
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.rvalid0     = r_rvalid0;
    assign bus.rvalid1     = r_rvalid1;
    assign bus.rdata       = r_rdata;
    assign bus.busy        = w_busy;
    assign bus.rom_address = w_rom_address;

endmodule : rom_word_arb
`default_nettype wire

// File: tb/tb_rom_word_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_word_arb
//  Description : Scoreboard bench for rom_word_arb. Stimulus pushes expected
//                grants and returned words into queues; a negedge monitor
//                pops and compares whenever a grant or rvalid appears.
//                Honours ROM_ARB_FIXED_PRIO_EN for the tie sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_word_arb;

    logic clk;
    logic reset;
    int   cycle;
    int   n_tests;
    int   n_fail;

    rom_word_arb_if bus ();

    rom_word_arb u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic port; logic [18:0] addr; } gexp_t;
    typedef struct { logic port; logic [15:0] data; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    gcyc_q[$];

`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam logic [4:0] TIE_PORTS = 5'b10000;   // bit k = port of grant k
`else
    localparam logic [4:0] TIE_PORTS = 5'b11010;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // ROM image: two fixed bytes, otherwise a byte-address hash.
    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        if (a == 20'h00246) return 8'hA5;
        if (a == 20'h00247) return 8'h3C;
        return a[7:0] ^ 8'h5A ^ a[19:12];
    endfunction

    always_comb bus.rom_datain = rom_byte(bus.rom_address);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_gnt0"},    {31'd0, bus.gnt0},    32'd0);
        check({pfx, "_gnt1"},    {31'd0, bus.gnt1},    32'd0);
        check({pfx, "_rvalid0"}, {31'd0, bus.rvalid0}, 32'd0);
        check({pfx, "_rvalid1"}, {31'd0, bus.rvalid1}, 32'd0);
        check({pfx, "_busy"},    {31'd0, bus.busy},    32'd0);
        check({pfx, "_romaddr"}, {12'd0, bus.rom_address}, 32'd0);
        check({pfx, "_rdata"},   {16'd0, bus.rdata},   32'd0);
    endtask

    task automatic wait_gnt(input string nm, output int cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no grant within 20 cycles", nm);
        end
        cyc = cycle;
    endtask

    // Monitor / scoreboard
    bit          lo_pending;
    logic [18:0] lo_addr;

    always @(negedge clk) begin
        if (!reset) begin
            lo_pending = 1'b0;
            gcyc_q.delete();
        end else begin
            if (lo_pending) begin
                check("lo_romaddr", {12'd0, bus.rom_address}, {12'd0, lo_addr, 1'b1});
                lo_pending = 1'b0;
            end
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
                check("gnt_busy", {31'd0, bus.busy}, 32'd1);
                if (gq.size() == 0) begin
                    check("gnt_unexpected", {31'd0, bus.gnt1}, 32'hFFFF_FFFF);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    check("gnt_port", {31'd0, bus.gnt1}, {31'd0, g.port});
                    check("hi_romaddr", {12'd0, bus.rom_address}, {12'd0, g.addr, 1'b0});
                    lo_addr    = g.addr;
                    lo_pending = 1'b1;
                end
                gcyc_q.push_back(cycle);
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                check("rv_onehot", {31'd0, bus.rvalid0 & bus.rvalid1}, 32'd0);
                if (rq.size() == 0) begin
                    check("rv_unexpected", {16'd0, bus.rdata}, 32'hFFFF_FFFF);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    check("rv_port", {31'd0, bus.rvalid1}, {31'd0, r.port});
                    check("rv_data", {16'd0, bus.rdata}, {16'd0, r.data});
                end
                if (gcyc_q.size() != 0)
                    check("rv_latency", cycle - gcyc_q.pop_front(), 32'd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c, prev;
        logic [4:0] tie;
        logic p;
        cycle   = 0;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        tie = TIE_PORTS;
        prev = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Tie held from reset
        for (int k = 0; k < 5; k++) begin
            p = tie[k];
            gq.push_back('{p, p ? 19'h00020 : 19'h00011});
            rq.push_back('{p, p ? 16'h1A1B : 16'h7879});
        end
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr0 = 19'h00011;
        bus.addr1 = 19'h00020;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("tie_gnt", c);
            if (k > 0) check("tie_gap", c - prev, 32'd2);
            prev = c;
            @(posedge clk); #1;
            if (k == 3) bus.req0 = 1'b0;
            if (k == 4) bus.req1 = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("tie_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Single fetch on port 0
        gq.push_back('{1'b0, 19'h00123});
        rq.push_back('{1'b0, 16'hA53C});
        bus.req0  = 1'b1;
        bus.addr0 = 19'h00123;
        wait_gnt("single_gnt", c);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back on port 1, second word at the top of the space
        gq.push_back('{1'b1, 19'h00020});
        rq.push_back('{1'b1, 16'h1A1B});
        gq.push_back('{1'b1, 19'h7FFFF});
        rq.push_back('{1'b1, 16'h5B5A});
        bus.req1  = 1'b1;
        bus.addr1 = 19'h00020;
        wait_gnt("b2b_gnt0", prev);
        @(posedge clk); #1;
        bus.addr1 = 19'h7FFFF;
        wait_gnt("b2b_gnt1", c);
        check("b2b_gap", c - prev, 32'd2);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during HI: no rvalid, all outputs cleared
        gq.push_back('{1'b1, 19'h00040});
        bus.req1  = 1'b1;
        bus.addr1 = 19'h00040;
        wait_gnt("rst_gnt", c);
        #1;
        reset    = 1'b0;
        bus.req1 = 1'b0;
        #2;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh request after release
        gq.push_back('{1'b1, 19'h00123});
        rq.push_back('{1'b1, 16'hA53C});
        bus.req1  = 1'b1;
        bus.addr1 = 19'h00123;
        wait_gnt("post_rst_gnt", c);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        repeat (6) @(negedge clk);

        check("gq_drained", gq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rom_word_arb
`default_nettype wire

// File: doc/rom_word_arb.md
ROM_WORD_ARB -- requirements
Module: rom_word_arb

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 req0  input  1  decoder-datapath word-fetch request (port 0).
REQ-004 addr0  input  19  port-0 word address.
REQ-005 req1  input  1  model-loader/host word-fetch request (port 1).
REQ-006 addr1  input  19  port-1 word address.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse to the winning port.
REQ-008 rvalid0, rvalid1  output  1 each  one-cycle pulse; the fetched word is on rdata.
REQ-009 rdata  output  16  assembled word, high byte first; shared by both ports.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 rom_address  output  20  byte address: {word address, byte select}; byte select 0 = high byte.
REQ-012 rom_datain  input  8  ROM byte; asynchronous read, valid in the same cycle as rom_address.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HI and LO.
REQ-014 IDLE: rom_address SHALL be 0; on an edge with req0|req1 high, arbitrate, latch winner id and address, go to HI.
REQ-015 The latching edge SHALL register gnt for the winner, high for exactly the HI cycle.
REQ-016 HI: rom_address = {addr_latched,1'b0}; at the next edge capture rom_datain into rdata[15:8], go to LO.
REQ-017 LO: rom_address = {addr_latched,1'b1}; at the next edge capture rom_datain into rdata[7:0] and register rvalid for the latched port for one cycle.
REQ-018 At the LO-exit edge, a pending request SHALL be arbitrated and the FSM go directly to HI (back-to-back); otherwise it goes to IDLE.
REQ-019 Throughput SHALL be one word per 2 cycles under continuous requests.
REQ-020 Latency: request accepted at edge E0 -> gnt in cycle E0..E1 -> rvalid and final rdata in cycle E2..E3.
REQ-021 A requester SHALL hold req and addr stable until it sees gnt, and drop req during the following (LO) cycle; req still high at the LO-exit edge is a new request.
REQ-022 rdata SHALL hold its value until the next HI/LO capture; rdata[15:8] updates one cycle before rvalid.
REQ-023 Simultaneous req0 and req1 SHALL be resolved round-robin: the port not granted last wins.
REQ-024 A single requester SHALL always win regardless of pointer.
REQ-025 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 SHALL be high in any cycle.
REQ-026 Addresses SHALL pass unchanged; all-ones 0x7FFFF SHALL map to byte addresses 0xFFFFE and 0xFFFFF with no wrap logic.

Reset
REQ-027 Reset low SHALL force IDLE, rdata=0, gnt*=0, rvalid*=0, busy=0, rom_address=0, and the latched address/id to 0.
REQ-028 Reset SHALL set the round-robin pointer so that port 0 wins the first tie.
REQ-029 Reset mid-fetch SHALL abort the fetch with no rvalid issued; the first request after release is arbitrated fresh.

Configuration
REQ-030 With ROM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win ties and the round-robin pointer SHALL be absent.
REQ-031 Without ROM_ARB_FIXED_PRIO_EN, REQ-023 round-robin applies.

Structure
REQ-032 Package rom_arb_pkg SHALL hold the constants ROM_WORD_AW=19, ROM_BYTE_W=8, ROM_WORD_W=16 and the state typedef {IDLE,HI,LO}.
REQ-033 Two-way arbitration SHALL live in a sub-module rr_arb2 (inputs: req pair and last-grant pointer; outputs: one-hot grant); the pointer register stays in rom_word_arb.

Verification
REQ-034 Single fetch: ROM[0x00246]=0xA5, ROM[0x00247]=0x3C; req0 with addr0=0x00123 -> gnt0 one cycle, rom_address 0x00246 then 0x00247, rvalid0 with rdata=0xA53C two cycles after gnt0 starts.
REQ-035 Tie, round-robin: req0 and req1 both held from reset -> grant order 0,1,0,1; one rvalid every 2 cycles; busy stays high.
REQ-036 Fixed priority: ROM_ARB_FIXED_PRIO_EN defined, req0 and req1 held -> port 0 granted every time; port 1 granted only after req0 drops.
REQ-037 Back-to-back: req1 re-raised during LO with addr1=0x7FFFF -> no IDLE cycle; rom_address 0xFFFFE then 0xFFFFF.
REQ-038 Reset mid-fetch: reset pulsed low during HI -> no rvalid; all outputs 0; next req1 is granted normally.
